// File: rtl/i2s_tx_stereo.sv
// Stereo I2S master transmitter: 1-deep holding register feeding a frame register,
// serialised MSB first with the standard one-BCLK delay after each LRCLK edge.
module i2s_tx_stereo #(
  parameter int unsigned BCLK_DIV = 4,
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned SLOT_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [SAMPLE_W-1:0] s_left,
  input  logic [SAMPLE_W-1:0] s_right,
  output logic                i2s_bclk,
  output logic                i2s_lrclk,
  output logic                i2s_sdata,
  output logic                frame_sync,
  output logic                underrun
);

  localparam int unsigned FrameBits = 2 * SLOT_W;
  localparam int unsigned DivW      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int unsigned BitW      = $clog2(FrameBits);
  localparam int unsigned IdxW      = $clog2(SAMPLE_W);

  localparam logic [DivW-1:0] DivLast   = DivW'(BCLK_DIV - 1);
  localparam logic [BitW-1:0] BitLast   = BitW'(FrameBits - 1);
  localparam logic [BitW-1:0] SlotStart = BitW'(SLOT_W);
  localparam logic [BitW-1:0] SampleTop = BitW'(SAMPLE_W);

  logic [DivW-1:0]     r_div_cnt;
  logic                r_bclk;
  logic [BitW-1:0]     r_bit_cnt;
  logic                r_lrclk;
  logic                r_sdata;
  logic                r_frame_sync;
  logic                r_underrun;
  logic                r_ready;
  logic [SAMPLE_W-1:0] r_hold_l;
  logic [SAMPLE_W-1:0] r_hold_r;
  logic [SAMPLE_W-1:0] r_frame_l;
  logic [SAMPLE_W-1:0] r_frame_r;

  logic                w_tick;
  logic                w_fall;
  logic [BitW-1:0]     w_bit_nxt;
  logic                w_load;
  logic                w_lr_nxt;
  logic [BitW-1:0]     w_pos;
  logic [IdxW-1:0]     w_idx;
  logic [SAMPLE_W-1:0] w_chan;
  logic                w_sdata_nxt;
  logic                w_accept;

  always_comb begin
    w_tick      = (r_div_cnt == DivLast);
    w_fall      = w_tick && r_bclk;
    w_bit_nxt   = (r_bit_cnt == BitLast) ? '0 : r_bit_cnt + 1'b1;
    w_load      = w_fall && (w_bit_nxt == '0);
    w_lr_nxt    = (w_bit_nxt >= SlotStart);
    w_pos       = w_lr_nxt ? (w_bit_nxt - SlotStart) : w_bit_nxt;
    w_chan      = w_lr_nxt ? r_frame_r : r_frame_l;
    // Slot position 1 carries the MSB; position 0 is the I2S delay bit.
    w_idx       = IdxW'(SampleTop - w_pos);
    w_sdata_nxt = 1'b0;
    if ((w_pos != '0) && (w_pos <= SampleTop)) begin
      w_sdata_nxt = w_chan[w_idx];
    end
    w_accept    = s_valid && r_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_bclk    <= 1'b0;
      r_bit_cnt <= BitLast;
      r_lrclk   <= 1'b1;
      r_sdata   <= 1'b0;
    end else begin
      if (w_tick) begin
        r_div_cnt <= '0;
        r_bclk    <= ~r_bclk;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end
      if (w_fall) begin
        r_bit_cnt <= w_bit_nxt;
        r_lrclk   <= w_lr_nxt;
        r_sdata   <= w_sdata_nxt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_sync <= 1'b0;
      r_underrun   <= 1'b0;
      r_ready      <= 1'b1;
      r_hold_l     <= '0;
      r_hold_r     <= '0;
      r_frame_l    <= '0;
      r_frame_r    <= '0;
    end else begin
      r_frame_sync <= w_load;
      r_underrun   <= w_load && r_ready;
      if (w_load) begin
        r_frame_l <= r_ready ? '0 : r_hold_l;
        r_frame_r <= r_ready ? '0 : r_hold_r;
      end
      // A load only drains a full holding register, so it never races an accept.
      if (w_load && !r_ready) begin
        r_ready <= 1'b1;
      end else if (w_accept) begin
        r_ready <= 1'b0;
      end
      if (w_accept) begin
        r_hold_l <= s_left;
        r_hold_r <= s_right;
      end
    end
  end

  assign s_ready    = r_ready;
  assign i2s_bclk   = r_bclk;
  assign i2s_lrclk  = r_lrclk;
  assign i2s_sdata  = r_sdata;
  assign frame_sync = r_frame_sync;
  assign underrun   = r_underrun;

endmodule

// File: tb/tb_i2s_tx_stereo.sv
// Bench for i2s_tx_stereo: scoreboard of expected frames plus timing checks at
// BCLK_DIV = 2 (main instance), 1 and 5.
module tb_i2s_tx_stereo;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic [63:0] want;  // serial stream, bit 63 first
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic [15:0] s_left = 16'h0;
  logic [15:0] s_right = 16'h0;
  logic        s_ready, frame_sync, underrun;
  logic        b2, l2, d2, b1, l1, d1, b5, l5, d5;
  logic        rdy1, fs1, ur1, rdy5, fs5, ur5;
  logic [2:0]  t_bclk, t_lrclk, t_sdata;

  always #5 clk = ~clk;

  i2s_tx_stereo #(.BCLK_DIV(2), .SAMPLE_W(16), .SLOT_W(32)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_left(s_left), .s_right(s_right), .i2s_bclk(b2), .i2s_lrclk(l2),
    .i2s_sdata(d2), .frame_sync(frame_sync), .underrun(underrun)
  );

  i2s_tx_stereo #(.BCLK_DIV(1), .SAMPLE_W(16), .SLOT_W(32)) dut_div1 (
    .clk(clk), .rst(rst), .s_valid(1'b0), .s_ready(rdy1),
    .s_left(16'h0), .s_right(16'h0), .i2s_bclk(b1), .i2s_lrclk(l1),
    .i2s_sdata(d1), .frame_sync(fs1), .underrun(ur1)
  );

  i2s_tx_stereo #(.BCLK_DIV(5), .SAMPLE_W(16), .SLOT_W(32)) dut_div5 (
    .clk(clk), .rst(rst), .s_valid(1'b0), .s_ready(rdy5),
    .s_left(16'h0), .s_right(16'h0), .i2s_bclk(b5), .i2s_lrclk(l5),
    .i2s_sdata(d5), .frame_sync(fs5), .underrun(ur5)
  );

  assign t_bclk  = {b5, b1, b2};
  assign t_lrclk = {l5, l1, l2};
  assign t_sdata = {d5, d1, d2};

  int   n_checks = 0;
  int   n_fail = 0;
  vec_t vecs[6];
  vec_t exp_q[$];
  vec_t cur_vec;
  vec_t pend;
  logic pend_v = 1'b0;
  vec_t m_cur;
  logic m_active = 1'b0;
  int   m_bit = 0;
  logic m_prev_bclk = 1'b0;
  int   since_rel = 0;
  int   last_fs = 0;
  logic seen_fs = 1'b0;
  logic bp_chk = 1'b0;
  logic [2:0] p_bclk, p_lr, p_sd;
  int   t_cnt[3];
  logic t_per_v[3];
  int   t_rises[3];
  logic t_lr_v[3];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic int div_of(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 5);
  endfunction

  // Monitor: reset values, frame scoreboard, frame_sync cadence and BCLK/LRCLK timing.
  initial begin : mon
    forever begin
      @(negedge clk);
      if (rst) begin
        check("reset_state", {b2, l2, d2, s_ready, frame_sync, underrun}, 6'b010100);
        exp_q.delete();
        pend_v = 1'b0;
        m_active = 1'b0;
        since_rel = 0;
        seen_fs = 1'b0;
        m_prev_bclk = b2;
        p_bclk = t_bclk;
        p_lr = t_lrclk;
        p_sd = t_sdata;
        for (int i = 0; i < 3; i++) begin
          t_cnt[i] = 0;
          t_per_v[i] = 1'b0;
          t_rises[i] = 0;
          t_lr_v[i] = 1'b0;
        end
      end else begin
        since_rel++;
        if (b2 && !m_prev_bclk && m_active) begin
          check("sdata_bit", d2, m_cur.want[63 - m_bit]);
          m_bit++;
          if (m_bit == 64) m_active = 1'b0;
        end
        if (underrun) check("underrun_with_fs", frame_sync, 1'b1);
        if (frame_sync) begin
          if (!seen_fs) check("first_fs_latency", since_rel, 4);
          else check("fs_spacing", since_rel - last_fs, 256);
          seen_fs = 1'b1;
          last_fs = since_rel;
          if (exp_q.size() > 0) begin
            m_cur = exp_q.pop_front();
            check("underrun", underrun, 1'b0);
          end else begin
            m_cur = '{l: 16'h0, r: 16'h0, want: 64'h0};
            check("underrun", underrun, 1'b1);
          end
          m_bit = 0;
          m_active = 1'b1;
        end
        // An accept lands in holding after any load on the same edge.
        if (pend_v) exp_q.push_back(pend);
        pend_v = s_valid && s_ready;
        pend = cur_vec;
        if (bp_chk) check("bp_ready", s_ready, frame_sync);
        m_prev_bclk = b2;
        for (int i = 0; i < 3; i++) begin
          t_cnt[i]++;
          if (t_bclk[i] && !p_bclk[i]) begin
            if (t_per_v[i]) check($sformatf("bclk_period_div%0d", div_of(i)), t_cnt[i], 2 * div_of(i));
            t_cnt[i] = 0;
            t_per_v[i] = 1'b1;
            if (t_lrclk[i]) t_rises[i]++;
          end
          if ((t_lrclk[i] != p_lr[i]) || (t_sdata[i] != p_sd[i]))
            check($sformatf("change_on_fall_div%0d", div_of(i)), p_bclk[i] && !t_bclk[i], 1'b1);
          if (t_lrclk[i] && !p_lr[i]) begin
            t_rises[i] = 0;
            t_lr_v[i] = 1'b1;
          end
          if (!t_lrclk[i] && p_lr[i] && t_lr_v[i])
            check($sformatf("lrclk_high_div%0d", div_of(i)), t_rises[i], 32);
        end
        p_bclk = t_bclk;
        p_lr = t_lrclk;
        p_sd = t_sdata;
      end
    end
  end

  task automatic send(input int idx);
    logic ok;
    ok = 1'b0;
    s_valid = 1'b1;
    s_left = vecs[idx].l;
    s_right = vecs[idx].r;
    cur_vec = vecs[idx];
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    check("send_accepted", ok, 1'b1);
  endtask

  task automatic wait_fs(input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n * 256 + 600; i++) begin
      @(negedge clk);
      if (frame_sync) seen++;
      if (seen == n) break;
    end
    check("wait_fs", seen, n);
  endtask

  initial begin : stim
    vecs[0] = '{l: 16'h8001, r: 16'h7FFE, want: 64'h40008000_3FFF0000};
    vecs[1] = '{l: 16'hFFFF, r: 16'h0000, want: 64'h7FFF8000_00000000};
    vecs[2] = '{l: 16'h1234, r: 16'hA5A5, want: 64'h091A0000_52D28000};
    vecs[3] = '{l: 16'h0001, r: 16'h8000, want: 64'h00008000_40000000};
    vecs[4] = '{l: 16'h5A5A, r: 16'hC3C3, want: 64'h2D2D0000_61E18000};
    vecs[5] = '{l: 16'h7FFF, r: 16'hFFFE, want: 64'h3FFF8000_7FFF0000};
    cur_vec = vecs[0];

    repeat (5) @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Frame 1 carries vecs[0]; frame 2 underruns.
    send(0);
    s_valid = 1'b0;
    wait_fs(2);

    // Back-pressure: three pairs queued with s_valid held high.
    @(posedge clk);
    #1;
    send(1);
    bp_chk = 1'b1;
    for (int i = 2; i <= 3; i++) send(i);
    s_valid = 1'b0;
    bp_chk = 1'b0;
    wait_fs(1);

    // Coincident accept and underrun load.
    repeat (255) @(posedge clk);
    #1;
    s_valid = 1'b1;
    s_left = vecs[4].l;
    s_right = vecs[4].r;
    cur_vec = vecs[4];
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    check("coinc_fs", frame_sync, 1'b1);
    check("coinc_underrun", underrun, 1'b1);
    check("coinc_ready_low", s_ready, 1'b0);
    wait_fs(2);

    // Mid-frame reset with a pair held: both are discarded.
    @(posedge clk);
    #1;
    send(5);
    s_valid = 1'b0;
    repeat (100) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_reset", {b2, l2, d2, s_ready, frame_sync, underrun}, 6'b010100);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    wait_fs(1);
    @(posedge clk);
    #1;
    send(5);
    s_valid = 1'b0;
    wait_fs(2);
    repeat (1400) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
